// File: rtl/axis_pkg.sv
// Shared types for the AXIS datapath library stream operators.
// Holds the state encoding used by the restoring divider.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        OUTPUT = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_restoring_stage.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_restoring_stage #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] wide_s;

    // Compare one bit wider so the shifted-out MSB still takes part in the test.
    always_comb begin
        wide_s = {rem_in, next_bit};
        if (wide_s >= {1'b0, divisor}) begin
            rem_out = WIDTH'(wide_s - {1'b0, divisor});
            q_bit   = 1'b1;
        end else begin
            rem_out = WIDTH'(wide_s);
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/axis_restoring_divider.sv
// Unsigned restoring divider joining a dividend stream and a divisor stream
// into one quotient stream; one quotient bit per cycle, one transaction at a time.
module axis_restoring_divider
    import axis_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 24,
    parameter int DIVISOR_WIDTH  = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_data,
    input  logic                      dividend_valid,
    output logic                      dividend_ready,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_data,
    input  logic                      divisor_valid,
    output logic                      divisor_ready,
    output logic [DIVIDEND_WIDTH-1:0] output_data,
    output logic                      output_err,
    output logic                      output_valid,
    input  logic                      output_ready
);

    localparam int REM_WIDTH = DIVISOR_WIDTH + 1;
    localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIVIDEND_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    div_state_t                state_r;
    logic [DIVIDEND_WIDTH-1:0] dividend_r;
    logic [DIVISOR_WIDTH-1:0]  divisor_r;
    logic [REM_WIDTH-1:0]      rem_r;
    logic [DIVIDEND_WIDTH-1:0] quot_r;
    logic [CNT_WIDTH-1:0]      cnt_r;
    logic [DIVIDEND_WIDTH-1:0] output_data_r;
    logic                      output_err_r;
    logic                      output_valid_r;

    logic                      accept_s;
    logic [REM_WIDTH-1:0]      rem_next_s;
    logic                      q_bit_s;

    // Both operands are taken together or not at all; nothing is offered while in reset.
    always_comb begin
        accept_s = 1'b0;
        if (rst && (state_r == IDLE)) begin
            accept_s = dividend_valid & divisor_valid;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign dividend_ready = accept_s;
    assign divisor_ready  = accept_s;

    div_restoring_stage #(
        .WIDTH (REM_WIDTH)
    ) u_stage (
        .rem_in   (rem_r),
        .next_bit (dividend_r[DIVIDEND_WIDTH-1]),
        .divisor  ({1'b0, divisor_r}),
        .rem_out  (rem_next_s),
        .q_bit    (q_bit_s)
    );

    // Transaction FSM: accept operands, iterate MSB first, then present the registered result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            dividend_r     <= '0;
            divisor_r      <= '0;
            rem_r          <= '0;
            quot_r         <= '0;
            cnt_r          <= CNT_ZERO;
            output_data_r  <= '0;
            output_err_r   <= 1'b0;
            output_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dividend_r <= dividend_data;
                        divisor_r  <= divisor_data;
                        rem_r      <= '0;
                        quot_r     <= '0;
                        cnt_r      <= CNT_LAST;
                        state_r    <= CALC;
                    end
                end
                CALC: begin
                    dividend_r <= {dividend_r[DIVIDEND_WIDTH-2:0], 1'b0};
                    rem_r      <= rem_next_s;
                    quot_r     <= {quot_r[DIVIDEND_WIDTH-2:0], q_bit_s};
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= OUTPUT;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                OUTPUT: begin
                    // First OUTPUT cycle loads the output registers; a zero divisor
                    // leaves the natural all-ones quotient and raises the error flag.
                    if (!output_valid_r) begin
                        output_data_r  <= quot_r;
                        output_err_r   <= (divisor_r == '0);
                        output_valid_r <= 1'b1;
                    end else if (output_ready) begin
                        output_valid_r <= 1'b0;
                        state_r        <= IDLE;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    output_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign output_data  = output_data_r;
    assign output_err   = output_err_r;
    assign output_valid = output_valid_r;

endmodule

// File: tb/tb_axis_restoring_divider.sv
// Self-checking bench for axis_restoring_divider: directed vector table,
// handshake corner sequences, reset during operation and randomized streaming.
module tb_axis_restoring_divider;

    localparam int DW = 24;
    localparam int VW = 9;
    localparam int NSTREAM = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dividend_data;
    logic          dividend_valid;
    logic          dividend_ready;
    logic [VW-1:0] divisor_data;
    logic          divisor_valid;
    logic          divisor_ready;
    logic [DW-1:0] output_data;
    logic          output_err;
    logic          output_valid;
    logic          output_ready;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_e[$];
    int            got;

    axis_restoring_divider #(
        .DIVIDEND_WIDTH (DW),
        .DIVISOR_WIDTH  (VW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dividend_data  (dividend_data),
        .dividend_valid (dividend_valid),
        .dividend_ready (dividend_ready),
        .divisor_data   (divisor_data),
        .divisor_valid  (divisor_valid),
        .divisor_ready  (divisor_ready),
        .output_data    (output_data),
        .output_err     (output_err),
        .output_valid   (output_valid),
        .output_ready   (output_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] d;
        logic [DW-1:0] q;
        logic          err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, required event never seen", name);
    endtask

    // Reference: floor division, zero divisor yields all ones with the error flag.
    function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, input logic [VW-1:0] d);
        if (d == '0) return {DW{1'b1}};
        return a / DW'(d);
    endfunction

    task automatic accept_pair(input logic [DW-1:0] a, input logic [VW-1:0] d);
        int n;
        @(negedge clk);
        dividend_data  = a;
        divisor_data   = d;
        dividend_valid = 1'b1;
        divisor_valid  = 1'b1;
        #1;
        n = 0;
        while (!(dividend_ready && divisor_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("accept");
        @(posedge clk);
        #1;
        dividend_valid = 1'b0;
        divisor_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!output_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) timeout("output_valid");
    endtask

    task automatic handshake();
        output_ready = 1'b1;
        @(posedge clk);
        #1;
        output_ready = 1'b0;
    endtask

    task automatic run_one(input logic [DW-1:0] a, input logic [VW-1:0] d,
                           output logic [DW-1:0] q, output logic err, output int lat);
        accept_pair(a, d);
        wait_valid(lat);
        q   = output_data;
        err = output_err;
        handshake();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] q;
        logic          e;
        int            lat;

        vecs[0]  = '{24'd12345,    9'd0,   24'hFFFFFF, 1'b1};
        vecs[1]  = '{24'd12346,    9'd1,   24'd12346,  1'b0};
        vecs[2]  = '{24'd12347,    9'd2,   24'd6173,   1'b0};
        vecs[3]  = '{24'hFFFFFF,   9'd511, 24'd32832,  1'b0};
        vecs[4]  = '{24'd0,        9'd5,   24'd0,      1'b0};
        vecs[5]  = '{24'd100,      9'd511, 24'd0,      1'b0};
        vecs[6]  = '{24'd511,      9'd511, 24'd1,      1'b0};
        vecs[7]  = '{24'hFFFFFF,   9'd1,   24'hFFFFFF, 1'b0};
        vecs[8]  = '{24'd1000,     9'd3,   24'd333,    1'b0};
        vecs[9]  = '{24'd0,        9'd0,   24'hFFFFFF, 1'b1};
        vecs[10] = '{24'h800000,   9'd256, 24'd32768,  1'b0};

        rst            = 1'b0;
        dividend_data  = 24'd77;
        divisor_data   = 9'd7;
        dividend_valid = 1'b1;
        divisor_valid  = 1'b1;
        output_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_readies", {30'd0, dividend_ready, divisor_ready}, 32'd0);
        check("reset_valid", {31'd0, output_valid}, 32'd0);
        check("reset_data", {8'd0, output_data}, 32'd0);
        check("reset_err", {31'd0, output_err}, 32'd0);
        dividend_valid = 1'b0;
        divisor_valid  = 1'b0;
        rst            = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_one(vecs[i].a, vecs[i].d, q, e, lat);
            check($sformatf("vec%0d_q", i), {8'd0, q}, {8'd0, vecs[i].q});
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_latency", i), lat, 32'd25);
        end

        // Lone dividend valid must never be accepted.
        @(negedge clk);
        dividend_data  = 24'd1000;
        divisor_data   = 9'd7;
        dividend_valid = 1'b1;
        divisor_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lone_valid_readies", {30'd0, dividend_ready, divisor_ready}, 32'd0);
        end
        divisor_valid = 1'b1;
        #1;
        check("pair_readies", {30'd0, dividend_ready, divisor_ready}, 32'd3);
        @(posedge clk);
        #1;
        check("ready_pulse_end", {30'd0, dividend_ready, divisor_ready}, 32'd0);
        dividend_valid = 1'b0;
        divisor_valid  = 1'b0;
        wait_valid(lat);
        check("lone_then_pair_q", {8'd0, output_data}, 32'd142);
        check("lone_then_pair_latency", lat, 32'd25);
        handshake();

        // Back-pressure in OUTPUT: result held, no new accept.
        accept_pair(24'd500000, 9'd300);
        wait_valid(lat);
        dividend_data  = 24'd999;
        divisor_data   = 9'd9;
        dividend_valid = 1'b1;
        divisor_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, output_valid}, 32'd1);
            check("hold_data", {8'd0, output_data}, 32'd1666);
            check("hold_err", {31'd0, output_err}, 32'd0);
            check("hold_readies", {30'd0, dividend_ready, divisor_ready}, 32'd0);
        end
        output_ready = 1'b1;
        #1;
        check("handshake_cycle_readies", {30'd0, dividend_ready, divisor_ready}, 32'd0);
        @(posedge clk);
        #1;
        output_ready   = 1'b0;
        dividend_valid = 1'b0;
        divisor_valid  = 1'b0;
        check("after_handshake_valid", {31'd0, output_valid}, 32'd0);

        // Reset mid-CALC discards the transaction.
        accept_pair(24'd777777, 9'd100);
        repeat (10) @(posedge clk);
        #3;
        rst            = 1'b0;
        dividend_valid = 1'b1;
        divisor_valid  = 1'b1;
        #1;
        check("rst_calc_valid", {31'd0, output_valid}, 32'd0);
        check("rst_calc_data", {8'd0, output_data}, 32'd0);
        check("rst_calc_readies", {30'd0, dividend_ready, divisor_ready}, 32'd0);
        @(negedge clk);
        dividend_valid = 1'b0;
        divisor_valid  = 1'b0;
        rst            = 1'b1;
        run_one(24'd777777, 9'd100, q, e, lat);
        check("post_rst_q", {8'd0, q}, 32'd7777);
        check("post_rst_err", {31'd0, e}, 32'd0);
        check("post_rst_latency", lat, 32'd25);

        // Reset while a result is presented.
        accept_pair(24'd9999, 9'd0);
        wait_valid(lat);
        check("pre_rst_out_err", {31'd0, output_err}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, output_valid}, 32'd0);
        check("rst_out_data", {8'd0, output_data}, 32'd0);
        check("rst_out_err", {31'd0, output_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Streaming with counting generators and random back-pressure.
        got = 0;
        fork
            begin
                for (int i = 0; i < NSTREAM; i++) begin
                    logic [DW-1:0] a_v;
                    logic [VW-1:0] d_v;
                    int            n;
                    a_v = (i % 3 == 2) ? DW'($urandom) : DW'(i * 419431 + 17);
                    d_v = VW'(i * 37);
                    @(negedge clk);
                    dividend_data  = a_v;
                    divisor_data   = d_v;
                    dividend_valid = 1'b1;
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clk);
                        check("stream_lone_readies", {30'd0, dividend_ready, divisor_ready}, 32'd0);
                    end
                    divisor_valid = 1'b1;
                    #1;
                    n = 0;
                    while (!(dividend_ready && divisor_ready) && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 200) timeout("stream_accept");
                    @(posedge clk);
                    exp_q.push_back(ref_q(a_v, d_v));
                    exp_e.push_back(d_v == '0);
                    #1;
                    dividend_valid = 1'b0;
                    divisor_valid  = 1'b0;
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (got < NSTREAM && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (output_valid && output_ready) begin
                        if (exp_q.size() == 0) begin
                            timeout("stream_unexpected_output");
                        end else begin
                            check($sformatf("stream%0d_q", got), {8'd0, output_data}, {8'd0, exp_q.pop_front()});
                            check($sformatf("stream%0d_err", got), {31'd0, output_err}, {31'd0, exp_e.pop_front()});
                        end
                        got++;
                    end
                    @(posedge clk);
                    #1;
                    output_ready = 1'($urandom_range(0, 1));
                end
                if (got < NSTREAM) timeout("stream_results");
            end
        join
        output_ready = 1'b0;
        check("stream_count", got, NSTREAM);
        check("stream_leftover", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
